uart_rx: RTL and testbench

//  UART receiver, 8N1, LSB first; receive-side counterpart of the team's uart_tx.

---
 rtl/uart_rx.sv | 163 ++++++++++++++++
 tb/tb_uart_rx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx: 8N1 UART receiver, LSB first.
// The serial line passes through a two-flop synchroniser. The start bit is
// validated at mid-bit. Each data bit and the stop bit are then sampled at
// mid-bit. A good frame updates data_out and raises data_valid for one cycle.
// A low stop bit raises frame_err for one cycle and the byte is discarded.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx #(
    parameter int CLK_FREQ = 12_000_000,
    parameter int BAUDRATE = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_in,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int          BAUD_CYCLES = CLK_FREQ / BAUDRATE;
    localparam int          HALF_CYCLES = BAUD_CYCLES / 2;
    localparam logic [31:0] BAUD_LAST   = 32'(BAUD_CYCLES - 1);
    localparam logic [31:0] HALF_LAST   = 32'(HALF_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

    logic        rx_meta_r;
    logic        rx_sync_r;
    logic        rx_s;
    state_t      state_r;
    logic [31:0] baud_cnt_r;
    logic [2:0]  bit_cnt_r;
    logic [7:0]  shift_r;
    logic [7:0]  data_out_r;
    logic        data_valid_r;
    logic        frame_err_r;
    logic        rx_busy_r;
    logic        half_hit_s;
    logic        bit_hit_s;

    assign rx_s       = rx_sync_r;
    assign half_hit_s = (baud_cnt_r == HALF_LAST);
    assign bit_hit_s  = (baud_cnt_r == BAUD_LAST);

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign frame_err  = frame_err_r;
    assign rx_busy    = rx_busy_r;

    // Two-flop synchroniser for the asynchronous line; resets to the idle level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_in;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Frame state machine with bit timing, shift register and registered strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            baud_cnt_r   <= 32'd0;
            bit_cnt_r    <= 3'd0;
            shift_r      <= 8'h00;
            data_out_r   <= 8'h00;
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            rx_busy_r    <= 1'b0;
        end else begin
            // Strobes last exactly one cycle unless set again below.
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    baud_cnt_r <= 32'd0;
                    bit_cnt_r  <= 3'd0;
                    if (!rx_s) begin
                        state_r   <= ST_START;
                        rx_busy_r <= 1'b1;
                    end else begin
                        state_r   <= ST_IDLE;
                        rx_busy_r <= 1'b0;
                    end
                end
                ST_START: begin
                    if (half_hit_s) begin
                        baud_cnt_r <= 32'd0;
                        bit_cnt_r  <= 3'd0;
                        if (!rx_s) begin
                            state_r <= ST_DATA;
                        end else begin
                            // Line went back high before mid-bit: a glitch.
                            state_r   <= ST_IDLE;
                            rx_busy_r <= 1'b0;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 32'd1;
                    end
                end
                ST_DATA: begin
                    if (bit_hit_s) begin
                        baud_cnt_r         <= 32'd0;
                        shift_r[bit_cnt_r] <= rx_s;
                        if (bit_cnt_r == 3'd7) begin
                            bit_cnt_r <= 3'd0;
                            state_r   <= ST_STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 32'd1;
                    end
                end
                ST_STOP: begin
                    if (bit_hit_s) begin
                        baud_cnt_r <= 32'd0;
                        if (rx_s) begin
                            // Leaving at mid-stop-bit means no dead time before the next start bit.
                            data_out_r   <= shift_r;
                            data_valid_r <= 1'b1;
                            state_r      <= ST_IDLE;
                            rx_busy_r    <= 1'b0;
                        end else begin
                            frame_err_r <= 1'b1;
                            state_r     <= ST_WAIT_IDLE;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 32'd1;
                    end
                end
                ST_WAIT_IDLE: begin
                    // Hold off until the line is released, so a break gives only one error.
                    baud_cnt_r <= baud_cnt_r + 32'd1;
                    if (rx_s) begin
                        state_r   <= ST_IDLE;
                        rx_busy_r <= 1'b0;
                    end else begin
                        state_r <= ST_WAIT_IDLE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    baud_cnt_r <= 32'd0;
                    bit_cnt_r  <= 3'd0;
                    rx_busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx: directed self-checking bench for uart_rx.
// The receiver is scaled to 50 clocks per bit (HALF = 25), so each frame is
// short to simulate. Expected values are computed by hand for that bit time.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int CLK_FREQ = 500_000;
    localparam int BAUDRATE = 10_000;
    localparam int BIT      = 50;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx_in = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       rx_busy;

    always #5 clk = ~clk;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUDRATE)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_in      (rx_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .rx_busy    (rx_busy)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    int         valid_cnt   = 0;
    int         err_cnt     = 0;
    int         busy_cnt    = 0;
    int         viol        = 0;
    int         last_valid_cyc = 0;
    logic [7:0] err_data    = 8'h00;
    logic [7:0] prev_data   = 8'h00;
    logic       prev_strobe = 1'b0;
    logic [7:0] rx_q[$];
    int         rd_idx      = 0;

    // Cycle counter used to time the valid pulse.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records received bytes, strobe counts and protocol violations.
    always @(negedge clk) begin
        if (data_valid) begin
            rx_q.push_back(data_out);
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
        end
        if (frame_err) begin
            err_cnt  <= err_cnt + 1;
            err_data <= data_out;
        end
        if ((data_valid && frame_err) ||
            ((data_valid || frame_err) && prev_strobe) ||
            ((data_out !== prev_data) && !data_valid && !reset))
            viol <= viol + 1;
        prev_strobe <= data_valid || frame_err;
        prev_data   <= data_out;
        if (rx_busy) busy_cnt <= busy_cnt + 1;
    end

    // Watchdog so that the run always terminates.
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_next(input string tag, input logic [7:0] exp);
        logic [31:0] obs;
        if (rd_idx < rx_q.size()) obs = {24'd0, rx_q[rd_idx]};
        else                      obs = 32'h0000_0100;
        rd_idx++;
        check(tag, obs, {24'd0, exp});
    endtask

    task automatic drive(input logic lvl, input int n);
        rx_in = lvl;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input int p, input logic stop_lvl);
        drive(1'b0, p);
        for (int i = 0; i < 8; i++) drive(b[i], p);
        drive(stop_lvl, p);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    initial begin
        int         v0;
        int         e0;
        int         b0;
        int         fall;
        int         lat;
        logic [7:0] c3;
        logic [7:0] exp_b [50];
        int         periods [2];

        periods[0] = 51;
        periods[1] = 49;

        repeat (3) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        check("rst_data_out",   {24'd0, data_out},   32'h0000_0000);
        check("rst_data_valid", {31'd0, data_valid}, 32'd0);
        check("rst_frame_err",  {31'd0, frame_err},  32'd0);
        check("rst_rx_busy",    {31'd0, rx_busy},    32'd0);
        drive(1'b1, 20);

        // Single byte 0xA5: value, pulse latency and busy duration.
        v0   = valid_cnt;
        b0   = busy_cnt;
        fall = cyc;
        send(8'hA5, BIT, 1'b1);
        drive(1'b1, 20);
        check("t1_count", 32'(valid_cnt - v0), 32'd1);
        check_next("t1_byte", 8'hA5);
        check("t1_data_out", {24'd0, data_out}, 32'h0000_00A5);
        lat = last_valid_cyc - fall;
        vectors++;
        assert ((lat >= 475) && (lat <= 479)) else begin
            miscompares++;
            $error("FAIL t1_latency: observed %0d expected 477+-2", lat);
        end
        check("t1_busy_cycles", 32'(busy_cnt - b0), 32'd475);

        // Back-to-back frames with no idle time between them.
        v0 = valid_cnt;
        e0 = err_cnt;
        send(8'h00, BIT, 1'b1);
        send(8'hFF, BIT, 1'b1);
        send(8'h01, BIT, 1'b1);
        drive(1'b1, 20);
        check("t2_count", 32'(valid_cnt - v0), 32'd3);
        check_next("t2_byte0", 8'h00);
        check_next("t2_byte1", 8'hFF);
        check_next("t2_byte2", 8'h01);
        check("t2_no_err", 32'(err_cnt - e0), 32'd0);

        // Short low glitch shorter than half a bit.
        v0 = valid_cnt;
        e0 = err_cnt;
        b0 = busy_cnt;
        drive(1'b0, 12);
        drive(1'b1, 100);
        check("t3_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("t3_no_err", 32'(err_cnt - e0), 32'd0);
        check("t3_data_out", {24'd0, data_out}, 32'h0000_0001);
        check("t3_busy_cycles", 32'(busy_cnt - b0), 32'd25);

        // Framing error followed by a break, then a good byte.
        do_reset();
        check("t4_rst_data_out", {24'd0, data_out}, 32'h0000_0000);
        v0 = valid_cnt;
        e0 = err_cnt;
        send(8'h3C, BIT, 1'b0);
        drive(1'b0, 200);
        check("t4_err_once", 32'(err_cnt - e0), 32'd1);
        check("t4_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("t4_err_data_out", {24'd0, err_data}, 32'h0000_0000);
        check("t4_data_out_held", {24'd0, data_out}, 32'h0000_0000);
        check("t4_busy_in_break", {31'd0, rx_busy}, 32'd1);
        drive(1'b1, 100);
        check("t4_idle_after_break", {31'd0, rx_busy}, 32'd0);
        send(8'h5A, BIT, 1'b1);
        drive(1'b1, 20);
        check("t4_err_still_once", 32'(err_cnt - e0), 32'd1);
        check("t4_valid_count", 32'(valid_cnt - v0), 32'd1);
        check_next("t4_byte", 8'h5A);
        check("t4_data_out", {24'd0, data_out}, 32'h0000_005A);

        // Reset in the middle of bit 4 of 0xC3.
        c3 = 8'hC3;
        v0 = valid_cnt;
        e0 = err_cnt;
        drive(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive(c3[i], BIT);
        drive(c3[4], 25);
        check("t5_busy_before", {31'd0, rx_busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t5_busy_after_reset", {31'd0, rx_busy}, 32'd0);
        drive(c3[4], 24);
        for (int i = 5; i < 8; i++) drive(c3[i], BIT);
        drive(1'b1, BIT);
        reset = 1'b0;
        drive(1'b1, 20);
        check("t5_no_valid", 32'(valid_cnt - v0), 32'd0);
        check("t5_no_err", 32'(err_cnt - e0), 32'd0);
        check("t5_data_out_cleared", {24'd0, data_out}, 32'h0000_0000);
        send(8'h7E, BIT, 1'b1);
        drive(1'b1, 20);
        check("t5_valid_count", 32'(valid_cnt - v0), 32'd1);
        check_next("t5_byte", 8'h7E);

        // Transmitter bit period offset by +2% and -2%, random bytes back to back.
        for (int k = 0; k < 2; k++) begin
            v0 = valid_cnt;
            e0 = err_cnt;
            for (int i = 0; i < 50; i++) begin
                exp_b[i] = 8'($urandom_range(0, 255));
                send(exp_b[i], periods[k], 1'b1);
            end
            drive(1'b1, 20);
            check("t6_count", 32'(valid_cnt - v0), 32'd50);
            check("t6_no_err", 32'(err_cnt - e0), 32'd0);
            for (int i = 0; i < 50; i++) check_next("t6_byte", exp_b[i]);
        end

        check("strobe_protocol", 32'(viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
